// File: rtl/ir_fusion_sched_if.sv
// IR sensing bus: A2D handshake plus the latched fusion results.
interface ir_fusion_sched_if;
    logic        en;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic [11:0] lft_IR;
    logic [11:0] rght_IR;
    logic        lft_opn;
    logic        rght_opn;
    logic [8:0]  IR_Dtrm;
    logic        en_fusion;
    logic        smpl_vld;
    logic        cnv_err;

    // Scheduler side
    modport master (
        input  en, cnv_cmplt, res,
        output strt_cnv, chnnl, lft_IR, rght_IR, lft_opn, rght_opn,
               IR_Dtrm, en_fusion, smpl_vld, cnv_err
    );

    // A2D / consumer side
    modport slave (
        output en, cnv_cmplt, res,
        input  strt_cnv, chnnl, lft_IR, rght_IR, lft_opn, rght_opn,
               IR_Dtrm, en_fusion, smpl_vld, cnv_err
    );
endinterface

// File: rtl/ir_fusion_sched.sv
// IR wall-sensor acquisition scheduler for the heading-fusion datapath.
// Converts left then right once per sample period, then derives the
// opening flags, the saturated derivative term and the fusion enable.
// Optional feature: define IR_FILTER_EN to average each new reading with
// the previously latched value (first sample after enable is raw).
module ir_fusion_sched #(
    parameter logic [2:0]  LFT_CHNNL  = 3'd1,
    parameter logic [2:0]  RGHT_CHNNL = 3'd0,
    parameter logic [15:0] SMPL_PER   = 16'd50000,
    parameter logic [11:0] OPN_THRES  = 12'h111,
    parameter int unsigned DTRM_SHFT  = 2,
    parameter logic [9:0]  CNV_TMO    = 10'd1023
) (
    input  logic               clk,
    input  logic               rst,
    ir_fusion_sched_if.master  bus
);

    localparam int unsigned RW = 12;   // reading width
    localparam int unsigned EW = 13;   // error width
    localparam int unsigned DW = 14;   // delta width
    localparam int unsigned OW = 9;    // derivative output width

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_PER = 3'd1,
        CNV_L    = 3'd2,
        WAIT_L   = 3'd3,
        CNV_R    = 3'd4,
        WAIT_R   = 3'd5,
        CALC     = 3'd6
    } state_t;

    state_t state_q, state_d;

    logic [15:0]          per_cnt_q;
    logic [9:0]           tmr_q;
    logic [RW-1:0]        lft_hold_q;
    logic [1:0]           smpl_cnt_q;
    logic signed [EW-1:0] prev_err_q;

    logic                 strt_q, strt_d;
    logic [2:0]           chnnl_q, chnnl_d;
    logic [RW-1:0]        lft_ir_q, rght_ir_q;
    logic                 lft_opn_q, rght_opn_q;
    logic [OW-1:0]        dtrm_q;
    logic                 fus_q;
    logic                 smpl_vld_q;
    logic                 cnv_err_q;

    logic                 ld_lft, ld_calc, set_err;
    logic                 per_wrap, tmo;

    logic [RW-1:0]        lft_filt_c, rght_filt_c;
    logic signed [EW-1:0] err_c;
    logic signed [DW-1:0] delta_c, dsh_c;
    logic signed [OW-1:0] sat_c;
    logic                 l_opn_c, r_opn_c;
    logic [1:0]           cnt_nxt_c;
    logic [OW-1:0]        dtrm_nxt_c;
    logic signed [EW-1:0] prev_nxt_c;
    logic                 fus_nxt_c;

    assign per_wrap = (per_cnt_q == (SMPL_PER - 16'd1));
    assign tmo      = (tmr_q == (CNV_TMO - 10'd1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and control strobes
    always_comb begin
        state_d = state_q;
        ld_lft  = 1'b0;
        ld_calc = 1'b0;
        set_err = 1'b0;
        if (!bus.en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     state_d = WAIT_PER;
                WAIT_PER: if (per_wrap) state_d = CNV_L;
                CNV_L:    state_d = WAIT_L;
                WAIT_L: begin
                    if (bus.cnv_cmplt) begin
                        state_d = CNV_R;
                        ld_lft  = 1'b1;
                    end else if (tmo) begin
                        state_d = WAIT_PER;
                        set_err = 1'b1;
                    end
                end
                CNV_R:    state_d = WAIT_R;
                WAIT_R: begin
                    if (bus.cnv_cmplt) begin
                        state_d = CALC;
                        ld_calc = 1'b1;
                    end else if (tmo) begin
                        state_d = WAIT_PER;
                        set_err = 1'b1;
                    end
                end
                CALC:     state_d = WAIT_PER;
                default:  state_d = IDLE;
            endcase
        end
        strt_d  = (state_d == CNV_L) || (state_d == CNV_R);
        chnnl_d = chnnl_q;
        if (state_d == CNV_L) chnnl_d = LFT_CHNNL;
        if (state_d == CNV_R) chnnl_d = RGHT_CHNNL;
    end

    // Optional averaging of new readings against the last latched value
`ifdef IR_FILTER_EN
    assign lft_filt_c  = (smpl_cnt_q == 2'd0) ? bus.res :
                         RW'((13'(bus.res) + 13'(lft_ir_q)) >> 1);
    assign rght_filt_c = (smpl_cnt_q == 2'd0) ? bus.res :
                         RW'((13'(bus.res) + 13'(rght_ir_q)) >> 1);
`else
    assign lft_filt_c  = bus.res;
    assign rght_filt_c = bus.res;
`endif

    // Error, delta and shifted derivative; right reading comes straight from res
    assign err_c   = $signed({1'b0, lft_hold_q}) - $signed({1'b0, rght_filt_c});
    assign delta_c = $signed({err_c[EW-1], err_c}) - $signed({prev_err_q[EW-1], prev_err_q});
    assign dsh_c   = delta_c >>> DTRM_SHFT;

    // Saturate the derivative to the 9-bit signed range
    always_comb begin
        sat_c = OW'(dsh_c);
        if (dsh_c > 14'sd255)       sat_c = 9'sd255;
        else if (dsh_c < -14'sd256) sat_c = $signed(9'h100);
    end

    assign l_opn_c    = (lft_hold_q < OPN_THRES);
    assign r_opn_c    = (rght_filt_c < OPN_THRES);
    assign cnt_nxt_c  = (smpl_cnt_q == 2'd2) ? 2'd2 : smpl_cnt_q + 2'd1;
    assign dtrm_nxt_c = ((smpl_cnt_q == 2'd0) || l_opn_c || r_opn_c) ? '0 : sat_c;
    assign prev_nxt_c = (l_opn_c || r_opn_c) ? '0 : err_c;
    assign fus_nxt_c  = (cnt_nxt_c == 2'd2) && !(l_opn_c && r_opn_c);

    // Free-running period counter and conversion timeout timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt_q <= '0;
            tmr_q     <= '0;
        end else begin
            if (state_q == IDLE)  per_cnt_q <= '0;
            else if (per_wrap)    per_cnt_q <= '0;
            else                  per_cnt_q <= per_cnt_q + 16'd1;

            if ((state_q == CNV_L) || (state_q == CNV_R))       tmr_q <= '0;
            else if ((state_q == WAIT_L) || (state_q == WAIT_R)) tmr_q <= tmr_q + 10'd1;
        end
    end

    // Sample datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strt_q     <= 1'b0;
            chnnl_q    <= '0;
            lft_hold_q <= '0;
            smpl_cnt_q <= '0;
            prev_err_q <= '0;
            lft_ir_q   <= '0;
            rght_ir_q  <= '0;
            lft_opn_q  <= 1'b0;
            rght_opn_q <= 1'b0;
            dtrm_q     <= '0;
            fus_q      <= 1'b0;
            smpl_vld_q <= 1'b0;
            cnv_err_q  <= 1'b0;
        end else begin
            strt_q     <= strt_d;
            chnnl_q    <= chnnl_d;
            smpl_vld_q <= ld_calc;

            if (ld_lft) lft_hold_q <= lft_filt_c;

            if (ld_calc) begin
                lft_ir_q   <= lft_hold_q;
                rght_ir_q  <= rght_filt_c;
                lft_opn_q  <= l_opn_c;
                rght_opn_q <= r_opn_c;
                dtrm_q     <= dtrm_nxt_c;
                prev_err_q <= prev_nxt_c;
                smpl_cnt_q <= cnt_nxt_c;
                fus_q      <= fus_nxt_c;
            end else if (state_q == IDLE) begin
                smpl_cnt_q <= '0;
            end

            if (!bus.en) fus_q <= 1'b0;

            if (!bus.en)      cnv_err_q <= 1'b0;
            else if (set_err) cnv_err_q <= 1'b1;
        end
    end

    assign bus.strt_cnv  = strt_q;
    assign bus.chnnl     = chnnl_q;
    assign bus.lft_IR    = lft_ir_q;
    assign bus.rght_IR   = rght_ir_q;
    assign bus.lft_opn   = lft_opn_q;
    assign bus.rght_opn  = rght_opn_q;
    assign bus.IR_Dtrm   = dtrm_q;
    assign bus.en_fusion = bus.en & fus_q;
    assign bus.smpl_vld  = smpl_vld_q;
    assign bus.cnv_err   = cnv_err_q;

endmodule

// File: tb/tb_ir_fusion_sched.sv
// Bench for ir_fusion_sched: directed sample sequences, an A2D responder,
// and a reference model of the fusion outputs checked every cycle.
module tb_ir_fusion_sched;

    logic clk = 1'b0;
    logic rst;
    ir_fusion_sched_if bus ();

    ir_fusion_sched #(.SMPL_PER(16'd16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] l;
        logic [11:0] r;
        logic        lo;
        logic        ro;
        logic [8:0]  dt;
        logic        fus;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t q[$];
    exp_t cur = '{l: 12'h0, r: 12'h0, lo: 1'b0, ro: 1'b0, dt: 9'h0, fus: 1'b0};

    // model history
    int m_l = 0, m_r = 0, m_prev = 0, m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected outputs of one completed sample, from the behavioural rules
    task automatic model_push(input int l, input int r);
        exp_t e;
        int lv, rv, err, d, dt;
        bit lo, ro;
        lv = l;
        rv = r;
`ifdef IR_FILTER_EN
        if (m_cnt > 0) begin
            lv = (l + m_l) / 2;
            rv = (r + m_r) / 2;
        end
`endif
        m_l = lv;
        m_r = rv;
        lo  = (lv < 'h111);
        ro  = (rv < 'h111);
        err = lv - rv;
        dt  = 0;
        if (m_cnt != 0 && !lo && !ro) begin
            d  = err - m_prev;
            dt = d >>> 2;
            if (dt > 255)  dt = 255;
            if (dt < -256) dt = -256;
        end
        m_prev = (lo || ro) ? 0 : err;
        if (m_cnt < 2) m_cnt++;
        e.l   = 12'(lv);
        e.r   = 12'(rv);
        e.lo  = lo;
        e.ro  = ro;
        e.dt  = 9'(dt);
        e.fus = (m_cnt == 2) && !(lo && ro);
        q.push_back(e);
    endtask

    // Per-cycle comparison against the model
    bit prev_strt = 1'b0;
    int last_strt = -1;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.smpl_vld) begin
                chk("smpl_vld_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) cur = q.pop_front();
            end
            if (!bus.en) cur.fus = 1'b0;
            chk("lft_IR",    int'(bus.lft_IR),    int'(cur.l));
            chk("rght_IR",   int'(bus.rght_IR),   int'(cur.r));
            chk("lft_opn",   int'(bus.lft_opn),   int'(cur.lo));
            chk("rght_opn",  int'(bus.rght_opn),  int'(cur.ro));
            chk("IR_Dtrm",   int'(bus.IR_Dtrm),   int'(cur.dt));
            chk("en_fusion", int'(bus.en_fusion), int'(bus.en & cur.fus));
            if (bus.strt_cnv) chk("strt_one_clk", int'(prev_strt), 0);
            if (!bus.en) begin
                last_strt = -1;
            end else if (bus.strt_cnv && bus.chnnl == 3'd1) begin
                if (last_strt >= 0) chk("start_spacing", (cyc - last_strt) % 16, 0);
                last_strt = cyc;
            end
            prev_strt = bus.strt_cnv;
        end
    end

    task automatic wait_strt(input logic [2:0] ch, output int at);
        int n;
        n  = 0;
        at = -1;
        @(negedge clk);
        while (!bus.strt_cnv && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("strt_seen", int'(bus.strt_cnv), 1);
        if (bus.strt_cnv) begin
            at = cyc;
            chk("chnnl", int'(bus.chnnl), int'(ch));
        end
    endtask

    // A2D responds five clocks after the request
    task automatic ack(input logic [11:0] v);
        repeat (5) @(posedge clk);
        #1 bus.cnv_cmplt = 1'b1;
        bus.res = v;
        @(posedge clk);
        #1 bus.cnv_cmplt = 1'b0;
        bus.res = 12'h000;
    endtask

    task automatic do_sample(input logic [11:0] l, input logic [11:0] r, output int t_l);
        int at;
        wait_strt(3'd1, t_l);
        if (t_l < 0) return;
        ack(l);
        wait_strt(3'd0, at);
        if (at < 0) return;
        model_push(int'(l), int'(r));
        ack(r);
        @(posedge clk);
        #1 chk("smpl_vld_timing", q.size(), 0);
    endtask

    int t0, tl, n;

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.cnv_cmplt = 1'b0;
        bus.res = 12'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_lft_IR",    int'(bus.lft_IR), 0);
        chk("rst_rght_IR",   int'(bus.rght_IR), 0);
        chk("rst_opn",       int'({bus.lft_opn, bus.rght_opn}), 0);
        chk("rst_IR_Dtrm",   int'(bus.IR_Dtrm), 0);
        chk("rst_en_fusion", int'(bus.en_fusion), 0);
        chk("rst_smpl_vld",  int'(bus.smpl_vld), 0);
        chk("rst_strt_cnv",  int'(bus.strt_cnv), 0);
        chk("rst_cnv_err",   int'(bus.cnv_err), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 bus.en = 1'b1;
        t0 = cyc;

        // Steady readings, then a 0x100 error step
        do_sample(12'h970, 12'h970, tl);
        chk("first_start_delay", int'((tl - t0) >= 16 && (tl - t0) <= 17), 1);
        chk("fus_after_1st", int'(bus.en_fusion), 0);
        do_sample(12'h970, 12'h970, tl);
        chk("fus_after_2nd", int'(bus.en_fusion), 1);
        do_sample(12'h9F0, 12'h8F0, tl);
`ifndef IR_FILTER_EN
        chk("dtrm_step_0x040", int'(bus.IR_Dtrm), 'h040);
`endif

        // Positive and negative saturation
        do_sample(12'h500, 12'h800, tl);
        do_sample(12'hFFF, 12'h200, tl);
`ifndef IR_FILTER_EN
        chk("dtrm_sat_pos", int'(bus.IR_Dtrm), 'h0FF);
`endif
        do_sample(12'h800, 12'h500, tl);
        do_sample(12'h200, 12'hFFF, tl);
`ifndef IR_FILTER_EN
        chk("dtrm_sat_neg", int'(bus.IR_Dtrm), 'h100);
`endif

        // Both openings
        do_sample(12'h050, 12'h060, tl);
`ifndef IR_FILTER_EN
        chk("both_open_flags", int'({bus.lft_opn, bus.rght_opn}), 3);
        chk("both_open_dtrm",  int'(bus.IR_Dtrm), 0);
        chk("both_open_fus",   int'(bus.en_fusion), 0);
`endif
        do_sample(12'h970, 12'h970, tl);

        // Withhold the right conversion acknowledge
        wait_strt(3'd1, tl);
        ack(12'h123);
        wait_strt(3'd0, tl);
        n = 0;
        while (!bus.cnv_err && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk("cnv_err_set", int'(bus.cnv_err), 1);

        // Next period proceeds normally, error stays sticky
        do_sample(12'h9F0, 12'h8F0, tl);
`ifndef IR_FILTER_EN
        chk("dtrm_after_tmo", int'(bus.IR_Dtrm), 'h040);
`endif
        chk("cnv_err_sticky", int'(bus.cnv_err), 1);

        // Drop enable in WAIT_L, then a late acknowledge
        wait_strt(3'd1, tl);
        repeat (2) @(posedge clk);
        #1 bus.en = 1'b0;
        m_cnt = 0;
        @(posedge clk);
        #1 bus.cnv_cmplt = 1'b1;
        bus.res = 12'h555;
        @(posedge clk);
        #1 bus.cnv_cmplt = 1'b0;
        repeat (40) begin
            @(negedge clk);
            chk("no_strt_disabled", int'(bus.strt_cnv), 0);
        end
        chk("cnv_err_cleared", int'(bus.cnv_err), 0);
        chk("fus_disabled", int'(bus.en_fusion), 0);

        // Re-enable: history restarts; filter averaging if built in
        @(posedge clk);
        #1 bus.en = 1'b1;
        do_sample(12'h800, 12'h800, tl);
        chk("fus_reenable_1st", int'(bus.en_fusion), 0);
        do_sample(12'hA00, 12'hA00, tl);
`ifdef IR_FILTER_EN
        chk("filter_lft_0x900", int'(bus.lft_IR), 'h900);
`else
        chk("raw_lft_0xA00", int'(bus.lft_IR), 'hA00);
`endif
        chk("fus_reenable_2nd", int'(bus.en_fusion), 1);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
